cmd_rt_registry: RTL and testbench

Real-time command registry feeding the burst sequencer `master_start`. A host word stream (SPI/UART decoder) writes commands as 12 32-bit words. The block assembles each command and queues it in a FIFO. It issues commands one at a time over the sequencer's `WR_DATA`/`MEM_*` load port, and discards commands whose start time can no longer be met. The next command is issued only after the sequencer finishes the current one, signalled by the falling edge of `REQ_COMMAND`.

---
 rtl/cmd_rt_registry.sv | 252 +++++++++++++++++++++++++
 tb/tb_cmd_rt_registry.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_rt_registry.sv
// Real-time command registry: assembles 12-word host commands, queues them and
// issues them one at a time to the burst sequencer, dropping commands already too late.
module cmd_rt_registry #(
  parameter int DEPTH = 16,
  parameter int LEAD  = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            IN_DATA,
  input  logic                   IN_WR,
  input  logic                   IN_SYNC,
  input  logic                   FLUSH,
  input  logic [63:0]            TIME,
  input  logic                   REQ_COMMAND,
  output logic                   WR_DATA,
  output logic [47:0]            MEM_DDS_freq,
  output logic [47:0]            MEM_DDS_delta_freq,
  output logic [31:0]            MEM_DDS_delta_rate,
  output logic [63:0]            MEM_TIME_START,
  output logic [15:0]            MEM_N_impuls,
  output logic [1:0]             MEM_TYPE_impulse,
  output logic [31:0]            MEM_Interval_Ti,
  output logic [31:0]            MEM_Interval_Tp,
  output logic [31:0]            MEM_Tblank1,
  output logic [31:0]            MEM_Tblank2,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   OVF,
  output logic [15:0]            DROP_CNT,
  output logic                   PENDING
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] dfreq;
    logic [31:0] drate;
    logic [63:0] tstart;
    logic [15:0] n_impuls;
    logic [1:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_ISSUE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      wcnt_reg;
  logic [3:0]      widx;
  logic            push_req, push, pop;
  logic            load_mem, drop, issue;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            ovf_reg, pending_reg;
  logic [15:0]     drop_cnt_reg;
  logic            req_q_reg, req_qq_reg, req_fall;
  logic [63:0]     time_lead;
  entry_t          entry_in, rd_data_reg, hold_reg;
  entry_t          mem_reg [DEPTH];
  logic            unused_bits;

  // A sync pulse makes a word written in the same cycle count as w0.
  assign widx     = IN_SYNC ? 4'd0 : wcnt_reg;
  assign push_req = IN_WR && (widx == 4'd11) && !FLUSH;
  assign push     = push_req && !FULL;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH)
      wcnt_reg <= 4'd0;
    else if (IN_WR)
      wcnt_reg <= (widx == 4'd11) ? 4'd0 : widx + 4'd1;
    else if (IN_SYNC)
      wcnt_reg <= 4'd0;
  end

  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_word
      logic [31:0] word_reg;
      always_ff @(posedge CLK) begin
        if (IN_WR && (widx == 4'(gi)))
          word_reg <= IN_DATA;
      end
    end
  endgenerate

  // w11 is never stored: it goes straight into the entry with the buffered words.
  always_comb begin
    entry_in.freq     = {g_word[1].word_reg[15:0], g_word[0].word_reg};
    entry_in.dfreq    = {g_word[3].word_reg[15:0], g_word[2].word_reg};
    entry_in.drate    = g_word[4].word_reg;
    entry_in.tstart   = {g_word[6].word_reg, g_word[5].word_reg};
    entry_in.n_impuls = g_word[7].word_reg[15:0];
    entry_in.typ      = g_word[7].word_reg[17:16];
    entry_in.ti       = g_word[8].word_reg;
    entry_in.tp       = g_word[9].word_reg;
    entry_in.tblank1  = g_word[10].word_reg;
    entry_in.tblank2  = IN_DATA;
  end

  assign unused_bits = ^{g_word[1].word_reg[31:16], g_word[3].word_reg[31:16],
                         g_word[7].word_reg[31:18]};

  always_ff @(posedge CLK) begin
    if (push)
      mem_reg[wr_ptr_reg] <= entry_in;
    rd_data_reg <= mem_reg[rd_ptr_reg];
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (push_req && FULL)
        ovf_reg <= 1'b1;
    end
  end

  assign LEVEL     = level_reg;
  assign FULL      = (level_reg == LW'(DEPTH));
  assign EMPTY     = (level_reg == '0);
  assign OVF       = ovf_reg;
  assign time_lead = TIME + 64'(LEAD);

  always_ff @(posedge CLK) begin
    if (RESET)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load_mem   = 1'b0;
    drop       = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!EMPTY && !pending_reg) begin
          pop        = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ:  state_next = S_CHECK;
      S_CHECK: begin
        if (hold_reg.tstart > time_lead) begin
          load_mem   = 1'b1;
          state_next = S_ISSUE;
        end else begin
          drop       = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        issue      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (FLUSH) begin
      state_next = S_IDLE;
      pop        = 1'b0;
      load_mem   = 1'b0;
      drop       = 1'b0;
      issue      = 1'b0;
    end
  end

  assign WR_DATA = issue;

  always_ff @(posedge CLK) begin
    if (state_reg == S_READ)
      hold_reg <= rd_data_reg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_DDS_freq       <= '0;
      MEM_DDS_delta_freq <= '0;
      MEM_DDS_delta_rate <= '0;
      MEM_TIME_START     <= '1;
      MEM_N_impuls       <= '0;
      MEM_TYPE_impulse   <= '0;
      MEM_Interval_Ti    <= '0;
      MEM_Interval_Tp    <= '0;
      MEM_Tblank1        <= '0;
      MEM_Tblank2        <= '0;
    end else if (load_mem) begin
      MEM_DDS_freq       <= hold_reg.freq;
      MEM_DDS_delta_freq <= hold_reg.dfreq;
      MEM_DDS_delta_rate <= hold_reg.drate;
      MEM_TIME_START     <= hold_reg.tstart;
      MEM_N_impuls       <= hold_reg.n_impuls;
      MEM_TYPE_impulse   <= hold_reg.typ;
      MEM_Interval_Ti    <= hold_reg.ti;
      MEM_Interval_Tp    <= hold_reg.tp;
      MEM_Tblank1        <= hold_reg.tblank1;
      MEM_Tblank2        <= hold_reg.tblank2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 16'hFFFF))
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign DROP_CNT = drop_cnt_reg;

  // Edge detect on the registered busy level; only the falling edge matters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q_reg  <= 1'b0;
      req_qq_reg <= 1'b0;
    end else begin
      req_q_reg  <= REQ_COMMAND;
      req_qq_reg <= req_q_reg;
    end
  end

  assign req_fall = req_qq_reg && !req_q_reg;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH)
      pending_reg <= 1'b0;
    else if (issue)
      pending_reg <= 1'b1;
    else if (req_fall)
      pending_reg <= 1'b0;
  end

  assign PENDING = pending_reg;

endmodule

// File: tb/tb_cmd_rt_registry.sv
// Directed bench for cmd_rt_registry: timing, field mapping, drop, overflow, framing, reset.
module tb_cmd_rt_registry;

  localparam logic [63:0] T0 = 64'h0000_0001_0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IN_DATA = '0;
  logic        IN_WR = 1'b0;
  logic        IN_SYNC = 1'b0;
  logic        FLUSH = 1'b0;
  logic [63:0] TIME = T0;
  logic        REQ_COMMAND = 1'b0;
  logic        WR_DATA;
  logic [47:0] MEM_DDS_freq, MEM_DDS_delta_freq;
  logic [31:0] MEM_DDS_delta_rate;
  logic [63:0] MEM_TIME_START;
  logic [15:0] MEM_N_impuls;
  logic [1:0]  MEM_TYPE_impulse;
  logic [31:0] MEM_Interval_Ti, MEM_Interval_Tp, MEM_Tblank1, MEM_Tblank2;
  logic [4:0]  LEVEL;
  logic        FULL, EMPTY, OVF, PENDING;
  logic [15:0] DROP_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int p0;

  always #5 CLK = ~CLK;

  cmd_rt_registry #(.DEPTH(16), .LEAD(4)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_WR(IN_WR), .IN_SYNC(IN_SYNC),
    .FLUSH(FLUSH), .TIME(TIME), .REQ_COMMAND(REQ_COMMAND), .WR_DATA(WR_DATA),
    .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
    .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
    .MEM_N_impuls(MEM_N_impuls), .MEM_TYPE_impulse(MEM_TYPE_impulse),
    .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Interval_Tp(MEM_Interval_Tp),
    .MEM_Tblank1(MEM_Tblank1), .MEM_Tblank2(MEM_Tblank2), .LEVEL(LEVEL),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .DROP_CNT(DROP_CNT), .PENDING(PENDING)
  );

  always @(posedge CLK) begin
    if (WR_DATA === 1'b1) begin
      pulses <= pulses + 1;
      $display("issue: Ti=%0d TIME_START=%h level=%0d", MEM_Interval_Ti, MEM_TIME_START, LEVEL);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic put_word(input logic [31:0] d);
    IN_DATA = d;
    IN_WR   = 1'b1;
    @(negedge CLK);
    IN_WR   = 1'b0;
  endtask

  // Returns in the cycle right after w11 was sampled.
  task automatic write_cmd(input logic [63:0] ts, input logic [31:0] ti);
    put_word(32'h5678_9ABC);
    put_word(32'hFFFF_1234);
    put_word(32'h0000_1111);
    put_word(32'hDEAD_A5A5);
    put_word(32'hCAFE_0001);
    put_word(ts[31:0]);
    put_word(ts[63:32]);
    put_word(32'hF00A_0042);
    put_word(ti);
    put_word(32'h0000_0064);
    put_word(32'h0000_0011);
    put_word(32'h0000_0022);
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    cycles(1);
    FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cycles(2);
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL reset_wr: got %b want 0", WR_DATA); end
    n_cmp++; if (LEVEL !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
    n_cmp++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", EMPTY, FULL); end
    n_cmp++; if (OVF !== 1'b0 || PENDING !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_pend: got %b/%b want 0/0", OVF, PENDING); end
    n_cmp++; if (DROP_CNT !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", DROP_CNT); end
    n_cmp++; if (MEM_TIME_START !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL reset_tstart: got %h want all ones", MEM_TIME_START); end
    n_cmp++; if (MEM_DDS_freq !== 48'd0 || MEM_Tblank2 !== 32'd0) begin n_bad++; $display("FAIL reset_fields: got freq=%h tb2=%h want 0", MEM_DDS_freq, MEM_Tblank2); end
    RESET = 1'b0;
    cycles(1);
  endtask

  task automatic test_single();
    write_cmd(T0 + 64'd1000, 32'd5);
    cycles(2);
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", WR_DATA); end
    cycles(1);
    n_cmp++; if (WR_DATA !== 1'b1) begin n_bad++; $display("FAIL single_wr: got %b want 1", WR_DATA); end
    n_cmp++; if (MEM_DDS_freq !== 48'h1234_5678_9ABC) begin n_bad++; $display("FAIL single_freq: got %h want 123456789abc", MEM_DDS_freq); end
    n_cmp++; if (MEM_DDS_delta_freq !== 48'hA5A5_0000_1111) begin n_bad++; $display("FAIL single_dfreq: got %h want a5a500001111", MEM_DDS_delta_freq); end
    n_cmp++; if (MEM_DDS_delta_rate !== 32'hCAFE_0001) begin n_bad++; $display("FAIL single_drate: got %h want cafe0001", MEM_DDS_delta_rate); end
    n_cmp++; if (MEM_TIME_START !== 64'h0000_0001_0000_03E8) begin n_bad++; $display("FAIL single_tstart: got %h want 00000001000003e8", MEM_TIME_START); end
    n_cmp++; if (MEM_N_impuls !== 16'h0042) begin n_bad++; $display("FAIL single_n: got %h want 0042", MEM_N_impuls); end
    n_cmp++; if (MEM_TYPE_impulse !== 2'b10) begin n_bad++; $display("FAIL single_type: got %b want 10", MEM_TYPE_impulse); end
    n_cmp++; if (MEM_Interval_Ti !== 32'd5) begin n_bad++; $display("FAIL single_ti: got %0d want 5", MEM_Interval_Ti); end
    n_cmp++; if (MEM_Interval_Tp !== 32'h64) begin n_bad++; $display("FAIL single_tp: got %h want 64", MEM_Interval_Tp); end
    n_cmp++; if (MEM_Tblank1 !== 32'h11 || MEM_Tblank2 !== 32'h22) begin n_bad++; $display("FAIL single_tblank: got %h/%h want 11/22", MEM_Tblank1, MEM_Tblank2); end
    n_cmp++; if (LEVEL !== 5'd0) begin n_bad++; $display("FAIL single_level: got %0d want 0", LEVEL); end
    cycles(1);
    n_cmp++; if (WR_DATA !== 1'b0 || PENDING !== 1'b1) begin n_bad++; $display("FAIL single_after: got wr=%b pend=%b want 0/1", WR_DATA, PENDING); end
  endtask

  task automatic test_back_to_back();
    p0 = pulses;
    REQ_COMMAND = 1'b1;
    write_cmd(T0 + 64'd1000, 32'd1);
    write_cmd(T0 + 64'd1000, 32'd2);
    write_cmd(T0 + 64'd1000, 32'd3);
    cycles(14);
    n_cmp++; if (pulses !== p0) begin n_bad++; $display("FAIL b2b_hold: got %0d pulses want %0d", pulses, p0); end
    n_cmp++; if (LEVEL !== 5'd3 || PENDING !== 1'b1) begin n_bad++; $display("FAIL b2b_queued: got level=%0d pend=%b want 3/1", LEVEL, PENDING); end
    REQ_COMMAND = 1'b0;
    cycles(1);
    n_cmp++; if (PENDING !== 1'b1) begin n_bad++; $display("FAIL b2b_pend_t1: got %b want 1", PENDING); end
    cycles(1);
    n_cmp++; if (PENDING !== 1'b0) begin n_bad++; $display("FAIL b2b_pend_t2: got %b want 0", PENDING); end
    cycles(2);
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL b2b_early: got %b want 0", WR_DATA); end
    cycles(1);
    n_cmp++; if (WR_DATA !== 1'b1 || MEM_Interval_Ti !== 32'd1) begin n_bad++; $display("FAIL b2b_issue1: got wr=%b ti=%0d want 1/1", WR_DATA, MEM_Interval_Ti); end
    n_cmp++; if (LEVEL !== 5'd2) begin n_bad++; $display("FAIL b2b_level: got %0d want 2", LEVEL); end
    cycles(1);
    n_cmp++; if (PENDING !== 1'b1) begin n_bad++; $display("FAIL b2b_pend_set: got %b want 1", PENDING); end
    REQ_COMMAND = 1'b1;
    cycles(3);
    REQ_COMMAND = 1'b0;
    cycles(5);
    n_cmp++; if (WR_DATA !== 1'b1 || MEM_Interval_Ti !== 32'd2) begin n_bad++; $display("FAIL b2b_issue2: got wr=%b ti=%0d want 1/2", WR_DATA, MEM_Interval_Ti); end
    cycles(1);
    do_flush();
    n_cmp++; if (LEVEL !== 5'd0 || EMPTY !== 1'b1 || PENDING !== 1'b0) begin n_bad++; $display("FAIL b2b_flush: got level=%0d empty=%b pend=%b want 0/1/0", LEVEL, EMPTY, PENDING); end
    n_cmp++; if (MEM_Interval_Ti !== 32'd2) begin n_bad++; $display("FAIL b2b_mem_keep: got %0d want 2", MEM_Interval_Ti); end
  endtask

  task automatic test_stale();
    p0 = pulses;
    write_cmd(T0 + 64'd2, 32'd7);
    write_cmd(T0 + 64'd4, 32'd8);
    cycles(3);
    n_cmp++; if (DROP_CNT !== 16'd2) begin n_bad++; $display("FAIL stale_drop: got %0d want 2", DROP_CNT); end
    n_cmp++; if (pulses !== p0 || PENDING !== 1'b0) begin n_bad++; $display("FAIL stale_noissue: got pulses=%0d pend=%b want %0d/0", pulses, PENDING, p0); end
    write_cmd(T0 + 64'd5, 32'd9);
    cycles(3);
    n_cmp++; if (WR_DATA !== 1'b1 || MEM_Interval_Ti !== 32'd9) begin n_bad++; $display("FAIL stale_next: got wr=%b ti=%0d want 1/9", WR_DATA, MEM_Interval_Ti); end
    n_cmp++; if (MEM_TIME_START !== 64'h0000_0001_0000_0005) begin n_bad++; $display("FAIL stale_tstart: got %h want 0000000100000005", MEM_TIME_START); end
    cycles(1);
    do_flush();
  endtask

  task automatic test_flush_issue();
    p0 = pulses;
    write_cmd(T0 + 64'd1000, 32'd10);
    cycles(3);
    FLUSH = 1'b1;
    #1;
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL flush_suppress: got %b want 0", WR_DATA); end
    cycles(1);
    FLUSH = 1'b0;
    n_cmp++; if (PENDING !== 1'b0 || pulses !== p0) begin n_bad++; $display("FAIL flush_after: got pend=%b pulses=%0d want 0/%0d", PENDING, pulses, p0); end
  endtask

  task automatic test_overflow();
    write_cmd(T0 + 64'd1000, 32'd11);
    cycles(4);
    for (int i = 0; i < 16; i++)
      write_cmd(T0 + 64'd1000, 32'(100 + i));
    n_cmp++; if (FULL !== 1'b1 || LEVEL !== 5'd16 || OVF !== 1'b0) begin n_bad++; $display("FAIL ovf_full16: got full=%b level=%0d ovf=%b want 1/16/0", FULL, LEVEL, OVF); end
    write_cmd(T0 + 64'd1000, 32'd200);
    n_cmp++; if (OVF !== 1'b1 || LEVEL !== 5'd16 || FULL !== 1'b1) begin n_bad++; $display("FAIL ovf_17: got ovf=%b level=%0d full=%b want 1/16/1", OVF, LEVEL, FULL); end
    n_cmp++; if (EMPTY !== 1'b0 || PENDING !== 1'b1) begin n_bad++; $display("FAIL ovf_state: got empty=%b pend=%b want 0/1", EMPTY, PENDING); end
    do_flush();
    n_cmp++; if (LEVEL !== 5'd0 || OVF !== 1'b0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin n_bad++; $display("FAIL ovf_flush: got level=%0d ovf=%b empty=%b full=%b want 0/0/1/0", LEVEL, OVF, EMPTY, FULL); end
  endtask

  task automatic test_framing();
    p0 = pulses;
    for (int i = 0; i < 5; i++)
      put_word(32'hBAD0_0000 + 32'(i));
    IN_SYNC = 1'b1;
    cycles(1);
    IN_SYNC = 1'b0;
    write_cmd(T0 + 64'd2000, 32'd12);
    cycles(2);
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL frame_early: got %b want 0", WR_DATA); end
    cycles(1);
    n_cmp++; if (WR_DATA !== 1'b1 || MEM_Interval_Ti !== 32'd12) begin n_bad++; $display("FAIL frame_issue: got wr=%b ti=%0d want 1/12", WR_DATA, MEM_Interval_Ti); end
    n_cmp++; if (MEM_DDS_freq !== 48'h1234_5678_9ABC || MEM_TIME_START !== 64'h0000_0001_0000_07D0) begin n_bad++; $display("FAIL frame_fields: got freq=%h ts=%h want 123456789abc/00000001000007d0", MEM_DDS_freq, MEM_TIME_START); end
    cycles(20);
    n_cmp++; if (pulses !== p0 + 1 || LEVEL !== 5'd0) begin n_bad++; $display("FAIL frame_count: got pulses=%0d level=%0d want %0d/0", pulses, LEVEL, p0 + 1); end
    do_flush();
  endtask

  task automatic test_reset_check();
    p0 = pulses;
    write_cmd(T0 + 64'd1000, 32'd13);
    cycles(2);
    RESET = 1'b1;
    cycles(1);
    n_cmp++; if (WR_DATA !== 1'b0) begin n_bad++; $display("FAIL rst_chk_wr: got %b want 0", WR_DATA); end
    n_cmp++; if (MEM_TIME_START !== 64'hFFFF_FFFF_FFFF_FFFF || MEM_Interval_Ti !== 32'd0) begin n_bad++; $display("FAIL rst_chk_mem: got ts=%h ti=%0d want all ones/0", MEM_TIME_START, MEM_Interval_Ti); end
    n_cmp++; if (PENDING !== 1'b0 || LEVEL !== 5'd0 || EMPTY !== 1'b1 || DROP_CNT !== 16'd0) begin n_bad++; $display("FAIL rst_chk_state: got pend=%b level=%0d empty=%b drop=%0d want 0/0/1/0", PENDING, LEVEL, EMPTY, DROP_CNT); end
    RESET = 1'b0;
    cycles(6);
    n_cmp++; if (pulses !== p0) begin n_bad++; $display("FAIL rst_chk_noissue: got %0d pulses want %0d", pulses, p0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stale();
    test_flush_issue();
    test_overflow();
    test_framing();
    test_reset_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
